// File: rtl/pipelined_add_sub.sv
// Segmented, pipelined two's-complement adder/subtractor with valid/ready on both sides.
// Optional signed saturation of the result is enabled by defining ADDSUB_SAT_EN.
module pipelined_add_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG_SAFE = (SEG == 0) ? 1 : SEG;
    localparam int unsigned STAGES   = (SEG == 0 || SEG > WIDTH) ? 1 : WIDTH / SEG;
    localparam int          LAST     = STAGES - 1;

    if (SEG == 0 || SEG > WIDTH || (WIDTH % SEG_SAFE) != 0) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a non-zero multiple of SEG");
    end

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic              r_ovf;

    logic              w_stall;
    logic              w_in_ready;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_ci;
    logic [WIDTH-1:0]  w_a  [STAGES];
    logic [WIDTH-1:0]  w_b  [STAGES];
    logic [WIDTH-1:0]  w_si [STAGES];
    logic [WIDTH-1:0]  w_s  [STAGES];
    logic [SEG:0]      w_seg [STAGES];
    logic              w_ovf;
    logic [WIDTH-1:0]  w_res;

    assign w_stall    = r_vld[LAST] && !out_ready;
    assign w_in_ready = !rst && !w_stall;

    always_comb begin
        // Stage 0 folds subtraction into an add: a + ~b + ~cin.
        w_v[0]  = in_valid && w_in_ready;
        w_a[0]  = a;
        w_b[0]  = sub ? ~b : b;
        w_ci[0] = sub ? ~cin : cin;
        w_si[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v[k]  = r_vld[k-1];
            w_a[k]  = r_a[k-1];
            w_b[k]  = r_b[k-1];
            w_ci[k] = r_c[k-1];
            w_si[k] = r_s[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_a[k][k*SEG +: SEG]} + {1'b0, w_b[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_ci[k]};
            w_s[k]   = w_si[k];
            w_s[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
        end

        w_ovf = (w_a[LAST][WIDTH-1] == w_b[LAST][WIDTH-1])
             && (w_s[LAST][WIDTH-1] != w_a[LAST][WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        w_res = w_s[LAST];
        if (w_ovf) begin
            w_res = w_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        w_res = w_s[LAST];
`endif
    end

    // The whole pipe advances or holds as one; bubbles are never collapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (!w_stall) begin
            r_vld <= w_v;
            for (int k = 0; k < STAGES; k++) begin
                if (w_v[k]) begin
                    r_a[k] <= w_a[k];
                    r_b[k] <= w_b[k];
                    r_c[k] <= w_seg[k][SEG];
                    r_s[k] <= (k == LAST) ? w_res : w_s[k];
                end
            end
            if (w_v[LAST]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_vld[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench: arithmetic scoreboard model plus directed vectors with literal results.
module tb_pipelined_add_sub;
    localparam int W   = 16;
    localparam int S   = 4;
    localparam int STG = W / S;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic iv4, ir4, cin4, sub4, ov4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int nvec = 0;
    int errs = 0;
    int cyc  = 0;
    bit rand_rdy = 1'b0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_add_sub #(.WIDTH(W), .SEG(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    pipelined_add_sub #(.WIDTH(4), .SEG(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(1'b1), .sum(sum4),
        .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Plain integer arithmetic: {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
        int ru, rs, sa, sb;
        logic [W-1:0] s;
        logic c, o;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!ms) begin
            ru = int'(ma) + int'(mb) + int'(mc);
            rs = sa + sb + int'(mc);
            c  = (ru > 65535);
        end else begin
            ru = int'(ma) - int'(mb) - int'(mc);
            rs = sa - sb - int'(mc);
            c  = (ru >= 0);
        end
        s = ru[W-1:0];
        o = (rs > 32767) || (rs < -32768);
        if (SAT && rs > 32767)  s = 16'h7FFF;
        if (SAT && rs < -32768) s = 16'h8000;
        return {o, c, s};
    endfunction

    // Scoreboard and hold checks, sampled on the falling edge.
    logic        stall_prev = 1'b0;
    logic [17:0] p_out;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            if (stall_prev) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_data", {ovf, cout, sum}, p_out);
            end
            if (out_valid) begin
                chk("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("scoreboard", {ovf, cout, sum}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            p_out      = {ovf, cout, sum};
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; leaves in_valid high on return so beats can go back-to-back.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, output int acc);
        logic rdy;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            nvec++; errs++;
            $display("FAIL send_timeout: got no in_ready, required one within 40 cycles");
        end
    endtask

    task automatic wait_out(output logic [W-1:0] s, output logic c, output logic o,
                            output int at);
        at = -1; s = '0; c = 1'b0; o = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                s = sum; c = cout; o = ovf; at = cyc;
                break;
            end
        end
        if (at < 0) begin
            nvec++; errs++;
            $display("FAIL wait_out_timeout: got no out_valid, required one within 40 cycles");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required completion in time");
        $fatal(1);
    end

    logic [W-1:0] gs;
    logic gc, go;
    int acc1, acc2, at, dummy;
    logic [W-1:0] vt_a [8] = '{16'h1234, 16'hABCD, 16'h8000, 16'h0000,
                               16'h7FFF, 16'h8000, 16'hFFFF, 16'h0F0F};
    logic [W-1:0] vt_b [8] = '{16'h4321, 16'h1111, 16'h8000, 16'h0001,
                               16'hFFFF, 16'h7FFF, 16'hFFFF, 16'hF0F0};
    logic [7:0] vt_c = 8'b1101_0010;
    logic [7:0] vt_s = 8'b0011_1000;
    logic [W-1:0] stall_exp [4] = '{16'h0002, 16'h0020, 16'h0200, 16'h2000};

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst4_out_valid", ov4, 0);
        step();
        rst = 1'b0;

        // Single-stage instance: one register of latency.
        a4 = 4'b1110; b4 = 4'b1100; cin4 = 1'b1; sub4 = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        chk("w4_in_ready", ir4, 1);
        step();
        a4 = 4'b0111; b4 = 4'b1000; cin4 = 1'b0; sub4 = 1'b1;
        @(negedge clk);
        chk("w4_add_valid", ov4, 1);
        chk("w4_add_sum", sum4, 4'b1011);
        chk("w4_add_cout", cout4, 1);
        chk("w4_add_ovf", ovf4, 0);
        step();
        iv4 = 1'b0;
        @(negedge clk);
        chk("w4_sub_valid", ov4, 1);
        chk("w4_sub_sum", sum4, SAT ? 4'b0111 : 4'b1111);
        chk("w4_sub_cout", cout4, 0);
        chk("w4_sub_ovf", ovf4, 1);
        step();
        @(negedge clk);
        chk("w4_bubble", ov4, 0);
        step();

        // Back-to-back beats and latency.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, acc1);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc2);
        in_valid = 1'b0;
        chk("b2b_accept", acc2, acc1 + 1);
        wait_out(gs, gc, go, at);
        chk("b2b_lat0", at, acc1 + STG - 1);
        chk("b2b_sum0", gs, 16'h0100);
        chk("b2b_cout0", gc, 0);
        wait_out(gs, gc, go, at);
        chk("b2b_lat1", at, acc1 + STG);
        chk("b2b_sum1", gs, 16'h0000);
        chk("b2b_cout1", gc, 1);
        chk("b2b_ovf1", go, 0);
        step();

        // Subtraction with borrow-in.
        send(16'h0005, 16'h0007, 1'b0, 1'b1, dummy);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, dummy);
        in_valid = 1'b0;
        wait_out(gs, gc, go, at);
        chk("sub_sum0", gs, 16'hFFFE);
        chk("sub_cout0", gc, 0);
        chk("sub_ovf0", go, 0);
        wait_out(gs, gc, go, at);
        chk("sub_sum1", gs, 16'hFFFD);
        step();

        // Signed overflow both directions.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, dummy);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, dummy);
        in_valid = 1'b0;
        wait_out(gs, gc, go, at);
        chk("ovf_pos_sum", gs, SAT ? 16'h7FFF : 16'h8000);
        chk("ovf_pos_flag", go, 1);
        chk("ovf_pos_cout", gc, 0);
        wait_out(gs, gc, go, at);
        chk("ovf_neg_sum", gs, SAT ? 16'h8000 : 16'h7FFF);
        chk("ovf_neg_flag", go, 1);
        chk("ovf_neg_cout", gc, 1);
        step();

        // Backpressure: fill the pipe, hold, then drain in order.
        out_ready = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, dummy);
        send(16'h0010, 16'h0010, 1'b0, 1'b0, dummy);
        send(16'h0100, 16'h0100, 1'b0, 1'b0, dummy);
        send(16'h1000, 16'h1000, 1'b0, 1'b0, dummy);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_sum", sum, 16'h0002);
        end
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_out(gs, gc, go, at);
            chk("drain_order", gs, stall_exp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_no_dup", out_valid, 0);
        end
        step();

        // Reset with three beats in flight.
        send(16'h1111, 16'h1111, 1'b0, 1'b0, dummy);
        send(16'h2222, 16'h2222, 1'b0, 1'b0, dummy);
        send(16'h3333, 16'h3333, 1'b0, 1'b0, dummy);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", out_valid, 0);
        end
        step();

        // Directed table under random consumer backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vt_a[i], vt_b[i], vt_c[i], vt_s[i], dummy);
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
